seg_display_arbiter: RTL and testbench



---
 rtl/seg_arb_pkg.sv | 13 +
 rtl/seg_display_arbiter_rr_arbiter.sv | 52 +++++
 rtl/seg_display_arbiter.sv | 120 ++++++++++++
 tb/tb_seg_display_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg_arb_pkg.sv
// Shared widths and FSM state type for the seven-segment display arbiter.
package seg_arb_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int SRC_W  = 3;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/seg_display_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request found at or
// above the pointer, wrapping around, and only while enabled.
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   grant_idx,
  output logic               grant_valid
);

  int dist_s;
  int best_s;

  // Pick the requester with the smallest rotated distance from the pointer.
  always_comb begin
    dist_s    = 0;
    best_s    = NUM_REQ;
    grant_idx = {PTR_W{1'b0}};
    for (int j = 0; j < NUM_REQ; j++) begin
      if (j >= int'(ptr)) begin
        dist_s = j - int'(ptr);
      end else begin
        dist_s = j + NUM_REQ - int'(ptr);
      end
      if (en && req[j] && (dist_s < best_s)) begin
        best_s    = dist_s;
        grant_idx = PTR_W'(j);
      end else begin
        best_s    = best_s;
      end
    end
  end

  assign grant_valid = (best_s < NUM_REQ);

  // Expand the winning index into a one-hot grant vector.
  always_comb begin
    grant = {NUM_REQ{1'b0}};
    for (int j = 0; j < NUM_REQ; j++) begin
      if (grant_valid && (grant_idx == PTR_W'(j))) begin
        grant[j] = 1'b1;
      end else begin
        grant[j] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/seg_display_arbiter.sv
// Shares the seven-segment display between requesters. Each accepted
// addr/data pair is latched and held for at least HOLD_CYCLES clocks.
module seg_display_arbiter
  import seg_arb_pkg::*;
#(
  parameter int NUM_REQ     = 3,
  parameter int HOLD_CYCLES = 50_000_000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [ADDR_W*NUM_REQ-1:0] req_addr,
  input  logic [DATA_W*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [ADDR_W-1:0]         disp_addr,
  output logic [DATA_W-1:0]         disp_data,
  output logic [SRC_W-1:0]          disp_src,
  output logic                      busy
);

  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam int PTR_W = $clog2(NUM_REQ);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(NUM_REQ - 1);

  state_t             state_r;
  state_t             state_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [CNT_W-1:0]   cnt_s;
  logic [PTR_W-1:0]   ptr_r;
  logic [PTR_W-1:0]   ptr_s;
  logic               window_s;
  logic               xfer_s;
  logic [NUM_REQ-1:0] grant_s;
  logic [PTR_W-1:0]   gidx_s;

  // Accepting only when no hold is running or the hold has just expired;
  // reset forces the window shut so ready drops immediately.
  assign window_s = ~rst & ((state_r == ST_IDLE) || (cnt_r == {CNT_W{1'b0}}));

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_arbiter (
    .req         (req_valid),
    .ptr         (ptr_r),
    .en          (window_s),
    .grant       (grant_s),
    .grant_idx   (gidx_s),
    .grant_valid (xfer_s)
  );

  assign req_ready = grant_s;

  // Next-state logic: a transfer restarts the hold, otherwise count down.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    ptr_s   = ptr_r;
    if (xfer_s) begin
      state_s = ST_HOLD;
      cnt_s   = HOLD_LOAD;
      if (gidx_s == PTR_LAST) begin
        ptr_s = {PTR_W{1'b0}};
      end else begin
        ptr_s = gidx_s + PTR_W'(1);
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_s = ST_IDLE;
        end
        ST_HOLD: begin
          if (cnt_r != {CNT_W{1'b0}}) begin
            cnt_s = cnt_r - CNT_W'(1);
          end else begin
            state_s = ST_IDLE;
          end
        end
        default: begin
          state_s = ST_IDLE;
          cnt_s   = {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // FSM, hold counter and round-robin pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      ptr_r   <= {PTR_W{1'b0}};
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      ptr_r   <= ptr_s;
    end
  end

  // Display registers latch the granted pair; busy mirrors the hold state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_addr <= {ADDR_W{1'b0}};
      disp_data <= {DATA_W{1'b0}};
      disp_src  <= {SRC_W{1'b0}};
      busy      <= 1'b0;
    end else begin
      if (xfer_s) begin
        disp_addr <= req_addr[ADDR_W*gidx_s +: ADDR_W];
        disp_data <= req_data[DATA_W*gidx_s +: DATA_W];
        disp_src  <= SRC_W'(gidx_s);
      end else begin
        disp_addr <= disp_addr;
      end
      busy <= (state_s == ST_HOLD);
    end
  end

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed bench: instance 0 uses HOLD_CYCLES=4, instance 1 uses HOLD_CYCLES=1.
// A time-based model (cycles since last accept) is checked every negedge.
module tb_seg_display_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  v     [2];
  logic [47:0] a     [2];
  logic [47:0] d     [2];
  logic [2:0]  rdy   [2];
  logic [15:0] daddr [2];
  logic [15:0] ddata [2];
  logic [2:0]  src   [2];
  logic        busy  [2];

  seg_display_arbiter #(.NUM_REQ(3), .HOLD_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .req_valid(v[0]), .req_addr(a[0]), .req_data(d[0]),
    .req_ready(rdy[0]), .disp_addr(daddr[0]), .disp_data(ddata[0]),
    .disp_src(src[0]), .busy(busy[0]));

  seg_display_arbiter #(.NUM_REQ(3), .HOLD_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(v[1]), .req_addr(a[1]), .req_data(d[1]),
    .req_ready(rdy[1]), .disp_addr(daddr[1]), .disp_data(ddata[1]),
    .disp_src(src[1]), .busy(busy[1]));

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec = nvec + 1;
    if (act !== exp) begin
      nerr = nerr + 1;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          hold  [2] = '{4, 1};
  int          cyc   = 0;
  bit          ever  [2] = '{1'b0, 1'b0};
  int          acc   [2] = '{0, 0};
  int          ptr   [2] = '{0, 0};
  logic [15:0] maddr [2] = '{16'h0, 16'h0};
  logic [15:0] mdata [2] = '{16'h0, 16'h0};
  int          msrc  [2] = '{0, 0};

  function automatic int pick(input logic [2:0] vv, input int p);
    for (int k = 0; k < 3; k++) begin
      if (vv[(p + k) % 3]) return (p + k) % 3;
    end
    return -1;
  endfunction

  // Window is open when nothing was ever shown or the hold has (nearly) run out.
  function automatic bit win(input int i);
    return !ever[i] || ((cyc - acc[i]) >= (hold[i] - 1));
  endfunction

  function automatic int grant_of(input int i);
    if (rst || !win(i)) return -1;
    return pick(v[i], ptr[i]);
  endfunction

  function automatic logic [2:0] exp_ready(input int i);
    int g;
    g = grant_of(i);
    if (g < 0) return 3'b000;
    return 3'(1 << g);
  endfunction

  // Model update on each clock edge; async reset clears it.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc <= 0;
      for (int i = 0; i < 2; i++) begin
        ever[i] <= 1'b0; acc[i] <= 0; ptr[i] <= 0;
        maddr[i] <= 16'h0; mdata[i] <= 16'h0; msrc[i] <= 0;
      end
    end else begin
      cyc <= cyc + 1;
      for (int i = 0; i < 2; i++) begin
        if (grant_of(i) >= 0) begin
          ever[i]  <= 1'b1;
          acc[i]   <= cyc + 1;
          maddr[i] <= a[i][16*grant_of(i) +: 16];
          mdata[i] <= d[i][16*grant_of(i) +: 16];
          msrc[i]  <= grant_of(i);
          ptr[i]   <= (grant_of(i) + 1) % 3;
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("ready%0d", i), 32'(rdy[i]), 32'(exp_ready(i)));
      chk($sformatf("addr%0d", i), 32'(daddr[i]), 32'(maddr[i]));
      chk($sformatf("data%0d", i), 32'(ddata[i]), 32'(mdata[i]));
      chk($sformatf("src%0d", i), 32'(src[i]), 32'(msrc[i]));
      chk($sformatf("busy%0d", i), 32'(busy[i]),
          (ever[i] && ((cyc - acc[i]) < hold[i])) ? 32'd1 : 32'd0);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
  endtask

  int gt[$];
  int gs[$];
  int exp_s[4] = '{0, 1, 2, 0};
  int exp_t[4] = '{1, 5, 9, 13};
  logic [15:0] last;

  initial begin
    v[0] = 3'b000; v[1] = 3'b000;
    a[0] = 48'h0; a[1] = 48'h0; d[0] = 48'h0; d[1] = 48'h0;
    #1;
    do_reset;
    chk("rst_busy", 32'(busy[0]), 32'd0);
    chk("rst_addr", 32'(daddr[0]), 32'd0);

    // single request from requester 0
    a[0][15:0] = 16'h0012; d[0][15:0] = 16'hBEEF; v[0] = 3'b001;
    #1 chk("t1_ready", 32'(rdy[0]), 32'h1);
    tick; v[0] = 3'b000;
    chk("t1_addr", 32'(daddr[0]), 32'h0012);
    chk("t1_data", 32'(ddata[0]), 32'hBEEF);
    chk("t1_src", 32'(src[0]), 32'd0);
    chk("t1_busy", 32'(busy[0]), 32'd1);
    repeat (3) tick;
    chk("t1_busy_hold", 32'(busy[0]), 32'd1);
    tick;
    chk("t1_busy_fall", 32'(busy[0]), 32'd0);

    // all three requesting continuously
    do_reset;
    a[0] = {16'hA002, 16'hA001, 16'hA000};
    d[0] = {16'hD002, 16'hD001, 16'hD000};
    v[0] = 3'b111;
    last = daddr[0];
    for (int t = 1; t <= 16; t++) begin
      tick;
      chk("t2_busy", 32'(busy[0]), 32'd1);
      if (daddr[0] !== last) begin
        gt.push_back(t);
        gs.push_back(int'(src[0]));
        last = daddr[0];
      end
    end
    v[0] = 3'b000;
    chk("t2_ngrants", 32'(gs.size()), 32'd4);
    for (int k = 0; k < 4 && k < gs.size(); k++) begin
      chk("t2_order", 32'(gs[k]), 32'(exp_s[k]));
      chk("t2_time", 32'(gt[k]), 32'(exp_t[k]));
    end

    // request arriving mid-hold waits for the window
    a[0][15:0] = 16'h0033; d[0][15:0] = 16'h3333; v[0] = 3'b001;
    #1 chk("t3_ready0", 32'(rdy[0]), 32'h1);
    tick; v[0] = 3'b000;
    a[0][31:16] = 16'h0044; d[0][31:16] = 16'h4444;
    tick; tick;
    v[0] = 3'b010;
    #1 chk("t3_wait", 32'(rdy[0]), 32'h0);
    tick;
    chk("t3_ready1", 32'(rdy[0]), 32'h2);
    tick; v[0] = 3'b000;
    chk("t3_src", 32'(src[0]), 32'd1);
    chk("t3_addr", 32'(daddr[0]), 32'h0044);

    // display retained after the hold expires
    repeat (4) tick;
    chk("t4_idle", 32'(busy[0]), 32'd0);
    repeat (110) tick;
    chk("t4_addr", 32'(daddr[0]), 32'h0044);
    chk("t4_data", 32'(ddata[0]), 32'h4444);

    // asynchronous reset mid-hold
    a[0][15:0] = 16'h0055; d[0][15:0] = 16'h5555; v[0] = 3'b001;
    tick; v[0] = 3'b000;
    tick;
    #1 rst = 1'b1;
    #1;
    chk("t5_ready", 32'(rdy[0]), 32'h0);
    chk("t5_addr", 32'(daddr[0]), 32'h0);
    chk("t5_data", 32'(ddata[0]), 32'h0);
    chk("t5_busy", 32'(busy[0]), 32'd0);
    tick; rst = 1'b0;
    a[0][47:32] = 16'h0077; d[0][47:32] = 16'h7777; v[0] = 3'b100;
    #1 chk("t5_ready2", 32'(rdy[0]), 32'h4);
    tick;
    chk("t5_src2", 32'(src[0]), 32'd2);
    chk("t5_addr2", 32'(daddr[0]), 32'h0077);
    v[0] = 3'b111;
    repeat (3) tick;
    chk("t5_wrap", 32'(rdy[0]), 32'h1);
    tick; v[0] = 3'b000;
    chk("t5_src0", 32'(src[0]), 32'd0);

    // HOLD_CYCLES=1 instance: grant every cycle
    a[1] = {16'hB002, 16'hB001, 16'hB000};
    d[1] = {16'hC002, 16'hC001, 16'hC000};
    v[1] = 3'b011;
    for (int k = 0; k < 8; k++) begin
      tick;
      chk("t6_src", 32'(src[1]), 32'(k % 2));
      chk("t6_busy", 32'(busy[1]), 32'd1);
    end
    v[1] = 3'b000;
    repeat (3) tick;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
